conv_output_streamer: RTL and testbench

- Reads the flat multi-filter convolution result bus, which is K feature maps of OH x OW words, and emits it one word per handshake on a valid/ready stream.
- Sits downstream of the multi-filter convolution layer. Feeds pooling/serial-out logic that cannot take the full flat bus.
- Tags each word with its channel/row/col and flags the final word.

---
 rtl/conv_output_streamer.sv | 129 ++++++++++++
 tb/tb_conv_output_streamer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/conv_output_streamer.sv
// Streams a flat K x OH x OW word bus out one word per valid/ready handshake,
// tagged with channel/row/col. Define OUT_RELU_EN to clamp negative words to zero.
module conv_output_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int K          = 6,
  parameter int OH         = 28,
  parameter int OW         = 28,
  localparam int CW = (K  > 1) ? $clog2(K)  : 1,
  localparam int RW = (OH > 1) ? $clog2(OH) : 1,
  localparam int XW = (OW > 1) ? $clog2(OW) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [0:K*OH*OW*DATA_WIDTH-1]  feature_map,
  output logic                           busy,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [CW-1:0]                  out_chan,
  output logic [RW-1:0]                  out_row,
  output logic [XW-1:0]                  out_col,
  output logic                           done
);

  localparam int NW = K * OH * OW;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         c, c_n;
  logic [RW-1:0]         r, r_n;
  logic [XW-1:0]         x, x_n;
  logic                  valid_n, last_n, busy_n, done_n, load;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] sel, data_n;

  always_comb begin
    state_n = state;
    c_n     = c;
    r_n     = r;
    x_n     = x;
    valid_n = out_valid;
    busy_n  = busy;
    done_n  = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = STREAM;
          c_n     = '0;
          r_n     = '0;
          x_n     = '0;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          load    = 1'b1;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (out_last) begin
            state_n = DONE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            load = 1'b1;
            if (x == XW'(OW - 1)) begin
              x_n = '0;
              if (r == RW'(OH - 1)) begin
                r_n = '0;
                c_n = c + CW'(1);
              end else begin
                r_n = r + RW'(1);
              end
            end else begin
              x_n = x + XW'(1);
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Last flag follows the counters being loaded, so K=OH=OW=1 flags word 0.
    last_n = valid_n && (c_n == CW'(K - 1)) && (r_n == RW'(OH - 1)) && (x_n == XW'(OW - 1));
  end

  always_comb begin
    idx = (IW'(c_n) * IW'(OH) + IW'(r_n)) * IW'(OW) + IW'(x_n);
    sel = feature_map[idx*DATA_WIDTH +: DATA_WIDTH];
`ifdef OUT_RELU_EN
    data_n = sel[DATA_WIDTH-1] ? '0 : sel;
`else
    data_n = sel;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      c         <= '0;
      r         <= '0;
      x         <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      c         <= c_n;
      r         <= r_n;
      x         <= x_n;
      out_valid <= valid_n;
      out_last  <= last_n;
      busy      <= busy_n;
      done      <= done_n;
      if (load) out_data <= data_n;
    end
  end

  assign out_chan = c;
  assign out_row  = r;
  assign out_col  = x;

endmodule

// File: tb/tb_conv_output_streamer.sv
// Directed bench for conv_output_streamer with K=OH=OW=2, 16-bit words.
module tb_conv_output_streamer;

  localparam int DW = 16;
  localparam int K  = 2;
  localparam int OH = 2;
  localparam int OW = 2;
  localparam int NW = K * OH * OW;

  logic              clk = 1'b0;
  logic              reset, start, out_ready;
  logic [0:NW*DW-1]  feature_map;
  logic              busy, out_valid, out_last, done;
  logic [DW-1:0]     out_data;
  logic              out_chan, out_row, out_col;

  logic [DW-1:0]     words [NW];
  int                nvec = 0;
  int                nerr = 0;

  conv_output_streamer #(.DATA_WIDTH(DW), .K(K), .OH(OH), .OW(OW)) dut (
    .clk(clk), .reset(reset), .start(start), .feature_map(feature_map),
    .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_chan(out_chan), .out_row(out_row), .out_col(out_col),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] v);
`ifdef OUT_RELU_EN
    return v[DW-1] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic load_map();
    for (int i = 0; i < NW; i++) feature_map[i*DW +: DW] = words[i];
  endtask

  task automatic check_word(input int w);
    chk($sformatf("valid[%0d]", w), out_valid, 1);
    chk($sformatf("busy[%0d]", w),  busy, 1);
    chk($sformatf("data[%0d]", w),  out_data, exp_word(words[w]));
    chk($sformatf("chan[%0d]", w),  out_chan, w / 4);
    chk($sformatf("row[%0d]", w),   out_row, (w / 2) % 2);
    chk($sformatf("col[%0d]", w),   out_col, w % 2);
    chk($sformatf("last[%0d]", w),  out_last, (w == NW - 1) ? 1 : 0);
    chk($sformatf("done_mid[%0d]", w), done, 0);
  endtask

  // Full stream; stall_at holds out_ready low for 3 extra cycles on that word,
  // restart_at pulses start while that word is presented.
  task automatic run_stream(input int stall_at, input int restart_at);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < NW; w++) begin
      check_word(w);
      if (w == restart_at) start = 1'b1;
      if (w == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          start = 1'b0;
          check_word(w);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("valid_after", out_valid, 0);
    chk("busy_after", busy, 0);
    chk("last_after", out_last, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("idle_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NW; i++) words[i] = DW'(i + 1);
    load_map();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_chan", out_chan, 0);
    reset = 1'b0;
    @(negedge clk);

    run_stream(-1, -1);   // basic
    run_stream(2, -1);    // backpressure on 0x0003
    run_stream(-1, 4);    // start ignored on 0x0005

    // Reset while 0x0004 is presented
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_data", out_data, 16'h0004);
    reset = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", out_data, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_stream(-1, -1);

    // Negative words: ReLU clamps them when enabled
    words[2] = 16'hC000;
    words[5] = 16'h8000;
    load_map();
    run_stream(-1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
